demux1to4_stream: RTL and testbench



---
 rtl/demux1to4_stream_if.sv | 18 +
 rtl/demux1to4_stream.sv | 51 +++++
 tb/tb_demux1to4_stream.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/demux1to4_stream_if.sv
// demux1to4_stream_if: input stream and four output channel handshakes of the 1-to-4 demux
interface demux1to4_stream_if #(parameter int WIDTH = 8);
  logic             In_valid;
  logic             In_ready;
  logic [WIDTH-1:0] In_data;
  logic [1:0]       Sel;
  logic [3:0]       Out_valid;
  logic [3:0]       Out_ready;
  logic [WIDTH-1:0] Y0, Y1, Y2, Y3;
  modport master (
    output In_valid, In_data, Sel, Out_ready,
    input  In_ready, Out_valid, Y0, Y1, Y2, Y3
  );
  modport slave (
    input  In_valid, In_data, Sel, Out_ready,
    output In_ready, Out_valid, Y0, Y1, Y2, Y3
  );
endinterface

// File: rtl/demux1to4_stream.sv
// demux1to4_stream: registered 1-to-4 stream demux with per-channel valid/ready; DEMUX_XFER_CNT_EN adds drain counters
module demux1to4_stream #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  demux1to4_stream_if.slave s
`ifdef DEMUX_XFER_CNT_EN
  ,
  output logic [63:0] Xfer_cnt
`endif
);
  logic [3:0]       vld;
  logic [WIDTH-1:0] y [4];
  logic             acc;
  logic [3:0]       drn;
  assign s.In_ready  = !vld[s.Sel] || s.Out_ready[s.Sel];
  assign acc         = s.In_valid && s.In_ready;
  assign drn         = vld & s.Out_ready;
  assign s.Out_valid = vld;
  assign s.Y0        = y[0];
  assign s.Y1        = y[1];
  assign s.Y2        = y[2];
  assign s.Y3        = y[3];
  // accept loads the selected channel; a drain without a refill empties it
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < 4; i++) y[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (acc && s.Sel == 2'(i)) begin
          y[i]   <= s.In_data;
          vld[i] <= 1'b1;
        end else if (drn[i]) begin
          vld[i] <= 1'b0;
        end
      end
    end
  end
`ifdef DEMUX_XFER_CNT_EN
  // saturating per-channel drain counters
  always_ff @(posedge clk) begin
    if (rst) Xfer_cnt <= '0;
    else
      for (int i = 0; i < 4; i++)
        if (drn[i] && Xfer_cnt[16*i +: 16] != 16'hFFFF)
          Xfer_cnt[16*i +: 16] <= Xfer_cnt[16*i +: 16] + 16'd1;
  end
`endif
endmodule

// File: tb/tb_demux1to4_stream.sv
// tb_demux1to4_stream: directed self-checking bench; define DEMUX_XFER_CNT_EN to also cover the counters
module tb_demux1to4_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared = 0;
  int   mismatched = 0;
  demux1to4_stream_if #(.WIDTH(8)) bus ();
`ifdef DEMUX_XFER_CNT_EN
  logic [63:0] xfer_cnt;
  demux1to4_stream #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .s(bus.slave), .Xfer_cnt(xfer_cnt));
`else
  demux1to4_stream #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .s(bus.slave));
`endif
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.In_valid = 1'b0;
    bus.In_data = 8'h00;
    bus.Sel = 2'd0;
    bus.Out_ready = 4'b0000;
    tick();
    tick();
    chk("reset out_valid", 64'(bus.Out_valid), 64'h0);
    chk("reset y0", 64'(bus.Y0), 64'h0);
    chk("reset y1", 64'(bus.Y1), 64'h0);
    chk("reset y2", 64'(bus.Y2), 64'h0);
    chk("reset y3", 64'(bus.Y3), 64'h0);
    chk("reset in_ready", 64'(bus.In_ready), 64'h1);
`ifdef DEMUX_XFER_CNT_EN
    chk("reset xfer_cnt", xfer_cnt, 64'h0);
`endif
    rst = 1'b0;
  endtask
  task automatic test_route();
    logic [7:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 4; k++) begin
      bus.Sel = 2'(k);
      bus.In_data = d[k];
      bus.In_valid = 1'b1;
      #1;
      chk($sformatf("route in_ready ch%0d", k), 64'(bus.In_ready), 64'h1);
      tick();
    end
    bus.In_valid = 1'b0;
    chk("route out_valid", 64'(bus.Out_valid), 64'hF);
    chk("route y0", 64'(bus.Y0), 64'h11);
    chk("route y1", 64'(bus.Y1), 64'h22);
    chk("route y2", 64'(bus.Y2), 64'h33);
    chk("route y3", 64'(bus.Y3), 64'h44);
    tick();
    chk("route hold y1", 64'(bus.Y1), 64'h22);
    bus.Sel = 2'd2;
    bus.In_data = 8'h99;
    bus.In_valid = 1'b1;
    #1;
    chk("stall in_ready", 64'(bus.In_ready), 64'h0);
    tick();
    bus.In_valid = 1'b0;
    chk("stall y2", 64'(bus.Y2), 64'h33);
    chk("stall out_valid", 64'(bus.Out_valid), 64'hF);
  endtask
  task automatic test_throughput();
    logic [7:0] d [3] = '{8'h55, 8'h66, 8'h77};
    bus.Sel = 2'd1;
    bus.Out_ready = 4'b0010;
    bus.In_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.In_data = d[k];
      #1;
      chk($sformatf("thru in_ready %0d", k), 64'(bus.In_ready), 64'h1);
      tick();
      chk($sformatf("thru y1 %0d", k), 64'(bus.Y1), 64'(d[k]));
      chk($sformatf("thru valid1 %0d", k), 64'(bus.Out_valid[1]), 64'h1);
    end
    bus.In_valid = 1'b0;
    bus.Out_ready = 4'b0000;
`ifdef DEMUX_XFER_CNT_EN
    chk("thru cnt1", 64'(xfer_cnt[31:16]), 64'd3);
    chk("thru cnt0", 64'(xfer_cnt[15:0]), 64'd0);
`endif
  endtask
  task automatic test_mixed_stall();
    bus.Out_ready = 4'b1000;
    tick();
    chk("drain3 out_valid", 64'(bus.Out_valid), 64'h7);
    bus.Out_ready = 4'b0000;
    bus.Sel = 2'd3;
    bus.In_data = 8'hA5;
    bus.In_valid = 1'b1;
    #1;
    chk("mixed in_ready", 64'(bus.In_ready), 64'h1);
    tick();
    bus.In_valid = 1'b0;
    chk("mixed y3", 64'(bus.Y3), 64'hA5);
    chk("mixed y0", 64'(bus.Y0), 64'h11);
    chk("mixed out_valid", 64'(bus.Out_valid), 64'hF);
  endtask
  task automatic test_reset_mid();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst out_valid", 64'(bus.Out_valid), 64'h0);
    chk("midrst y0", 64'(bus.Y0), 64'h0);
    bus.Out_ready = 4'b1111;
    tick();
    chk("midrst no stale", 64'(bus.Out_valid), 64'h0);
    bus.Out_ready = 4'b0000;
  endtask
  task automatic test_back_to_back();
    bus.Sel = 2'd0;
    bus.In_data = 8'h5A;
    bus.In_valid = 1'b1;
    tick();
    bus.Sel = 2'd1;
    bus.In_data = 8'h3C;
    bus.Out_ready = 4'b0001;
    tick();
    bus.In_valid = 1'b0;
    bus.Out_ready = 4'b0000;
    chk("b2b out_valid", 64'(bus.Out_valid), 64'h2);
    chk("b2b y0 held", 64'(bus.Y0), 64'h5A);
    chk("b2b y1", 64'(bus.Y1), 64'h3C);
  endtask
`ifdef DEMUX_XFER_CNT_EN
  task automatic test_saturation();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.Sel = 2'd0;
    bus.In_data = 8'h01;
    bus.In_valid = 1'b1;
    bus.Out_ready = 4'b0001;
    repeat (65538) tick();
    bus.In_valid = 1'b0;
    bus.Out_ready = 4'b0000;
    chk("sat cnt0", 64'(xfer_cnt[15:0]), 64'hFFFF);
  endtask
`endif
  initial begin
    test_reset();
    test_route();
    test_throughput();
    test_mixed_stall();
    test_reset_mid();
    test_back_to_back();
`ifdef DEMUX_XFER_CNT_EN
    test_saturation();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
